// File: rtl/bin2bcd_feeder.sv
// -----------------------------------------------------------------------------
// bin2bcd_feeder
//
// Converts a 14-bit unsigned binary value to four packed BCD digits with a
// sequential shift-add-3 (double-dabble) engine. One iteration runs per clock,
// and 14 iterations make one conversion. The result, the decimal-point mask
// and the blanking control are registered. They connect straight to the
// Hexs/Points/LES inputs of the seven-segment display stage. The result
// outputs hold their old value until a conversion completes, so the display
// never shows partial digits.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   RST     in   1   asynchronous active-low reset
//   bin     in  14   binary value (0..9999 valid, 10000..16383 overflow)
//   dp      in   4   decimal-point mask, sampled with an accepted start
//   start   in   1   conversion request, honoured only when idle
//   Hexs    out 16   BCD result, [3:0] ones .. [15:12] thousands
//   Points  out  4   dp captured at the accepted start
//   LES     out  1   display blank (1 = blank)
//   busy    out  1   conversion in progress
//   done    out  1   one-cycle pulse when the result outputs update
//   ovf     out  1   last converted value was above 9999
//
// Configuration macro:
//   OVF_BLANK_EN - when defined, an overflowing result also blanks the
//                  display (LES = 1). When undefined, LES is cleared on
//                  every completed conversion.
// -----------------------------------------------------------------------------
module bin2bcd_feeder (
    input  logic        clk,
    input  logic        RST,
    input  logic [13:0] bin,
    input  logic [3:0]  dp,
    input  logic        start,
    output logic [15:0] Hexs,
    output logic [3:0]  Points,
    output logic        LES,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [33:0] shift_r;
    logic [33:0] shift_s;
    logic [3:0]  cnt_r;
    logic [3:0]  dp_r;
    logic        accept_s;
    logic        last_s;

    // One double-dabble iteration: correct each BCD nibble, then shift left.
    function automatic logic [33:0] dabble_step(input logic [33:0] v);
        logic [33:0] adj;
        adj = v;
        for (int i = 0; i < 5; i++) begin
            if (adj[14 + 4*i +: 4] >= 4'd5) begin
                adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4] + 4'd3;
            end else begin
                adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4];
            end
        end
        return {adj[32:0], 1'b0};
    endfunction

    // Next-state logic and iteration datapath.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        shift_s  = dabble_step(shift_r);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_CONV;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_CONV: begin
                // The counter reaches 14 on this edge, so the final shift
                // happens here.
                if (cnt_r == 4'd13) begin
                    last_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CONV;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, shift register, counter and captured dp.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
            shift_r <= 34'd0;
            cnt_r   <= 4'd0;
            dp_r    <= 4'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                shift_r <= {20'd0, bin};
                cnt_r   <= 4'd0;
                dp_r    <= dp;
            end else if (state_r == ST_CONV) begin
                shift_r <= shift_s;
                cnt_r   <= cnt_r + 4'd1;
            end else begin
                shift_r <= shift_r;
                cnt_r   <= cnt_r;
            end
        end
    end

    // Registered display-facing outputs; they change only on completion or reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            Hexs   <= 16'd0;
            Points <= 4'd0;
            LES    <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= last_s;
            if (accept_s) begin
                busy <= 1'b1;
            end else if (last_s) begin
                busy <= 1'b0;
            end else begin
                busy <= busy;
            end
            if (last_s) begin
                Hexs   <= shift_s[29:14];
                Points <= dp_r;
                // The fifth digit is never displayed; it only flags overflow.
                ovf    <= (shift_s[33:30] != 4'd0);
`ifdef OVF_BLANK_EN
                LES    <= (shift_s[33:30] != 4'd0);
`else
                LES    <= 1'b0;
`endif
            end else begin
                Hexs   <= Hexs;
                Points <= Points;
                ovf    <= ovf;
                LES    <= LES;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_feeder.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_feeder
//
// Directed self-checking bench for bin2bcd_feeder. Expected values are
// hand-computed constants, plus a decimal-arithmetic reference for the
// strided value sweep.
// -----------------------------------------------------------------------------
module tb_bin2bcd_feeder;

    logic        clk;
    logic        RST;
    logic [13:0] bin;
    logic [3:0]  dp;
    logic        start;
    logic [15:0] Hexs;
    logic [3:0]  Points;
    logic        LES;
    logic        busy;
    logic        done;
    logic        ovf;

    int vec_cnt;
    int err_cnt;
    int cyc;
    int t0;

    bin2bcd_feeder dut (
        .clk    (clk),
        .RST    (RST),
        .bin    (bin),
        .dp     (dp),
        .start  (start),
        .Hexs   (Hexs),
        .Points (Points),
        .LES    (LES),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle count used for latency measurement.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle start. Returns at the negedge after the accepting edge.
    task automatic pulse_start(input logic [13:0] b, input logic [3:0] d);
        @(negedge clk);
        bin   = b;
        dp    = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    // Wait (bounded) for done. Report the latency from acceptance, the number
    // of busy cycles seen before done, and whether Hexs held its value.
    task automatic wait_done(output int lat, output int busy_n, output bit held);
        logic [15:0] h0;
        bit          seen;
        h0     = Hexs;
        held   = 1'b1;
        busy_n = (busy === 1'b1) ? 1 : 0;
        seen   = 1'b0;
        lat    = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat  = cyc - t0;
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            if (Hexs !== h0) held = 1'b0;
        end
        if (!seen) begin
            chk_val("done_timeout", 32'd0, 32'd1);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        int lat;
        int bn;
        bit held;
        int dcnt;
        logic exp_les;

        vec_cnt = 0;
        err_cnt = 0;
        RST     = 1'b0;
        bin     = 14'd0;
        dp      = 4'd0;
        start   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk_val("rst_hexs",   32'(Hexs),   32'h0);
        chk_val("rst_points", 32'(Points), 32'h0);
        chk_val("rst_les",    32'(LES),    32'h1);
        chk_val("rst_busy",   32'(busy),   32'h0);
        chk_val("rst_done",   32'(done),   32'h0);
        chk_val("rst_ovf",    32'(ovf),    32'h0);
        RST = 1'b1;
        repeat (2) @(negedge clk);

        // Basic conversion: 1234 with dp 0100.
        pulse_start(14'd1234, 4'b0100);
        chk_val("busy_after_start", 32'(busy), 32'h1);
        wait_done(lat, bn, held);
        chk_val("lat_1234",    32'(lat),    32'd14);
        chk_val("busy_cycles", 32'(bn),     32'd14);
        chk_val("hexs_held",   32'(held),   32'd1);
        chk_val("hexs_1234",   32'(Hexs),   32'h1234);
        chk_val("points_0100", 32'(Points), 32'h4);
        chk_val("les_1234",    32'(LES),    32'h0);
        chk_val("ovf_1234",    32'(ovf),    32'h0);
        chk_val("busy_at_done",32'(busy),   32'h0);

        // Back-to-back: 0, then 9999 started in the done cycle of the first.
        pulse_start(14'd0, 4'b0001);
        wait_done(lat, bn, held);
        chk_val("hexs_0",  32'(Hexs), 32'h0000);
        chk_val("lat_0",   32'(lat),  32'd14);
        pulse_start(14'd9999, 4'b1000);
        chk_val("done_width", 32'(done), 32'h0);
        chk_val("b2b_busy",   32'(busy), 32'h1);
        wait_done(lat, bn, held);
        chk_val("lat_9999",    32'(lat),    32'd14);
        chk_val("hexs_9999",   32'(Hexs),   32'h9999);
        chk_val("points_1000", 32'(Points), 32'h8);

        // Overflow values.
`ifdef OVF_BLANK_EN
        exp_les = 1'b1;
`else
        exp_les = 1'b0;
`endif
        pulse_start(14'd10000, 4'b0000);
        wait_done(lat, bn, held);
        chk_val("hexs_10000", 32'(Hexs), 32'h0000);
        chk_val("ovf_10000",  32'(ovf),  32'h1);
        chk_val("les_10000",  32'(LES),  32'(exp_les));
        pulse_start(14'd16383, 4'b0000);
        wait_done(lat, bn, held);
        chk_val("hexs_16383", 32'(Hexs), 32'h6383);
        chk_val("ovf_16383",  32'(ovf),  32'h1);
        pulse_start(14'd5, 4'b0000);
        wait_done(lat, bn, held);
        chk_val("ovf_clear", 32'(ovf), 32'h0);
        chk_val("les_clear", 32'(LES), 32'h0);

        // Start during CONV is ignored: 42, then 777 requested at cycle 5.
        pulse_start(14'd42, 4'b0010);
        repeat (3) @(negedge clk);
        bin   = 14'd777;
        dp    = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bn, held);
        chk_val("lat_42",    32'(lat),    32'd14);
        chk_val("hexs_42",   32'(Hexs),   32'h0042);
        chk_val("points_42", 32'(Points), 32'h2);
        dcnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        chk_val("no_queued_done", 32'(dcnt), 32'd0);

        // Reset at cycle 7 of a conversion aborts it.
        pulse_start(14'd500, 4'b0110);
        repeat (6) @(negedge clk);
        RST = 1'b0;
        #1;
        chk_val("mid_rst_hexs",   32'(Hexs),   32'h0);
        chk_val("mid_rst_points", 32'(Points), 32'h0);
        chk_val("mid_rst_les",    32'(LES),    32'h1);
        chk_val("mid_rst_busy",   32'(busy),   32'h0);
        chk_val("mid_rst_ovf",    32'(ovf),    32'h0);
        dcnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        @(negedge clk);
        RST = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        chk_val("mid_rst_no_done", 32'(dcnt), 32'd0);
        pulse_start(14'd2025, 4'b0001);
        wait_done(lat, bn, held);
        chk_val("post_rst_hexs", 32'(Hexs), 32'h2025);
        chk_val("post_rst_les",  32'(LES),  32'h0);

        // Strided sweep against the decimal reference, plus the edge values.
        for (int v = 0; v < 16384; v += 97) begin
            pulse_start(14'(v), 4'b0000);
            wait_done(lat, bn, held);
            chk_val($sformatf("sweep_hexs_%0d", v), 32'(Hexs), 32'(ref_bcd(v)));
            chk_val($sformatf("sweep_ovf_%0d", v),  32'(ovf),  32'(v > 9999));
        end
        for (int v = 9998; v <= 10001; v++) begin
            pulse_start(14'(v), 4'b0000);
            wait_done(lat, bn, held);
            chk_val($sformatf("edge_hexs_%0d", v), 32'(Hexs), 32'(ref_bcd(v)));
            chk_val($sformatf("edge_ovf_%0d", v),  32'(ovf),  32'(v > 9999));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
